my_ram: RTL and testbench

//   Word-addressable register file (RAM) built from DEPTH clocked WIDTH-bit registers.
//   - Write path: the load strobe is steered to one register by a 1:DEPTH demux tree,

---
 rtl/my_ram.sv | 109 ++++++++++
 tb/tb_my_ram.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/my_ram.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : my_ram (with leaf cells my_mux, my_dmux)
//  Purpose  : Word-addressable register file of 2**ADDR_W words of WIDTH bits.
//             Writes steer the load strobe through a 1:DEPTH demux tree;
//             reads select the addressed word through a DEPTH:1 mux tree.
//  Revision : 1.0  - initial release
// ============================================================================

// ----------------------------------------------------------------------------
//  my_mux : 2:1 word multiplexer, sel=0 -> a, sel=1 -> b
// ----------------------------------------------------------------------------
module my_mux #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] out
);
    assign out = sel ? b : a;
endmodule

// ----------------------------------------------------------------------------
//  my_dmux : 1:2 single-bit demultiplexer, sel=0 -> a, sel=1 -> b
// ----------------------------------------------------------------------------
module my_dmux (
    input  logic in,
    input  logic sel,
    output logic a,
    output logic b
);
    assign a = in & ~sel;
    assign b = in &  sel;
endmodule

// ----------------------------------------------------------------------------
//  my_ram : register file top
// ----------------------------------------------------------------------------
module my_ram #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  in,
    input  logic              load,
    input  logic [ADDR_W-1:0] addr,
    output logic [WIDTH-1:0]  out
);
    localparam int c_DEPTH = 1 << ADDR_W;
    localparam int c_NODES = 2 * c_DEPTH - 1;

    // Both trees use heap numbering: node n has children 2n+1 / 2n+2, the
    // root is node 0, and leaf c_DEPTH-1+k corresponds to word k because the
    // tree is walked MSB of addr first.
    logic             w_dnode [c_NODES];
    logic [WIDTH-1:0] w_mnode [c_NODES];
    logic             w_en    [c_DEPTH];
    logic [WIDTH-1:0] r_mem   [c_DEPTH];

    assign w_dnode[0] = load;
    assign out        = w_mnode[0];

    genvar d, j, k;
    generate
        for (d = 0; d < ADDR_W; d++) begin : g_level
            for (j = 0; j < (1 << d); j++) begin : g_node
                localparam int c_NODE = (1 << d) - 1 + j;

                my_dmux u_dmux (
                    .in  (w_dnode[c_NODE]),
                    .sel (addr[ADDR_W-1-d]),
                    .a   (w_dnode[2*c_NODE+1]),
                    .b   (w_dnode[2*c_NODE+2])
                );

                my_mux #(.WIDTH(WIDTH)) u_mux (
                    .a   (w_mnode[2*c_NODE+1]),
                    .b   (w_mnode[2*c_NODE+2]),
                    .sel (addr[ADDR_W-1-d]),
                    .out (w_mnode[c_NODE])
                );
            end
        end

        for (k = 0; k < c_DEPTH; k++) begin : g_leaf
            assign w_en[k]               = w_dnode[c_DEPTH-1+k];
            assign w_mnode[c_DEPTH-1+k]  = r_mem[k];
        end
    endgenerate

    // Storage: each word captures in when its decoded enable is high; async clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < c_DEPTH; i++) begin
                if (w_en[i]) begin
                    r_mem[i] <= in;
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_my_ram.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_my_ram
//  Purpose  : Self-checking bench for my_ram against an array reference model.
//  Revision : 1.0  - initial release
// ============================================================================
module tb_my_ram;
    localparam int WIDTH  = 16;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk;
    logic              rst_n;
    logic [WIDTH-1:0]  in;
    logic              load;
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  out;

    logic [WIDTH-1:0]  model [DEPTH];
    int                errors;
    int                checks;

    my_ram #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (in),
        .load  (load),
        .addr  (addr),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flag illegal stimulus: unknown addr/load while a write could happen.
    always @(posedge clk) begin
        if (rst_n === 1'b1 && load !== 1'b0 && $isunknown({addr, load})) begin
            errors++;
            $error("FAIL stim_xz observed addr=%b load=%b required known values", addr, load);
        end
    end

    task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                         input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Read every address combinationally and compare with the model.
    task automatic sweep(input string tag);
        for (int a = 0; a < DEPTH; a++) begin
            addr = a[ADDR_W-1:0];
            #1;
            check(tag, out, model[a]);
        end
    endtask

    // One write edge: checks read-during-write shows old data, then new data.
    task automatic write(input string tag, input int a, input logic [WIDTH-1:0] d);
        addr = a[ADDR_W-1:0];
        in   = d;
        load = 1'b1;
        #1;
        check({tag, "_rdw"}, out, model[a]);
        tick();
        model[a] = d;
        check({tag, "_after"}, out, model[a]);
        load = 1'b0;
    endtask

    task automatic model_clear();
        for (int a = 0; a < DEPTH; a++) model[a] = '0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        load   = 1'b0;
        addr   = '0;
        in     = '0;
        model_clear();

        // 1. Reset: held low for two cycles, then sweep during and after reset
        tick();
        tick();
        sweep("reset_held");
        tick();
        rst_n = 1'b1;
        #1;
        sweep("reset_released");

        // 2. Single write to addr 5
        tick();
        write("single5", 5, 16'hABCD);
        addr = 3'd4; #1; check("single_nbr4", out, 16'h0000);
        addr = 3'd6; #1; check("single_nbr6", out, 16'h0000);
        addr = 3'd5; #1; check("single_hold5", out, 16'hABCD);

        // 3. Fill and readback, boundaries at addr 0 and 7
        tick();
        for (int a = 0; a < DEPTH; a++) begin
            write("fill", a, 16'h1000 + 16'(a));
        end
        sweep("fill_sweep");
        addr = 3'd0; #1; check("fill_lo", out, 16'h1000);
        addr = 3'd7; #1; check("fill_hi", out, 16'h1007);

        // 4. Hold: load low, in all ones, addr toggling for 10 edges
        in   = 16'hFFFF;
        load = 1'b0;
        for (int e = 0; e < 10; e++) begin
            addr = ADDR_W'($urandom_range(0, DEPTH - 1));
            tick();
        end
        sweep("hold_sweep");

        // 5. Overwrite addr 3 on back-to-back edges
        tick();
        addr = 3'd3;
        in   = 16'h1234;
        load = 1'b1;
        tick();
        model[3] = 16'h1234;
        check("ovw_edge1", out, 16'h1234);
        in = 16'h5678;
        tick();
        model[3] = 16'h5678;
        check("ovw_edge2", out, 16'h5678);
        load = 1'b0;
        sweep("ovw_sweep");

        // Randomized traffic with mid-cycle addr glitches
        tick();
        for (int n = 0; n < 80; n++) begin
            int a, g;
            logic [WIDTH-1:0] d;
            logic             we;
            a  = $urandom_range(0, DEPTH - 1);
            g  = $urandom_range(0, DEPTH - 1);
            d  = WIDTH'($urandom);
            we = 1'($urandom_range(0, 1));
            addr = ADDR_W'(g);
            load = we;
            in   = d;
            #1;
            check("rand_glitch", out, model[g]);
            addr = ADDR_W'(a);
            #1;
            check("rand_pre", out, model[a]);
            tick();
            if (we) model[a] = d;
            check("rand_post", out, model[a]);
            load = 1'b0;
        end
        sweep("rand_sweep");

        // 6. Async reset mid-run after restoring the fill pattern
        tick();
        for (int a = 0; a < DEPTH; a++) begin
            write("refill", a, 16'h1000 + 16'(a));
        end
        addr = 3'd2;
        in   = 16'hBEEF;
        load = 1'b1;
        #1;
        rst_n = 1'b0;
        model_clear();
        #1;
        check("areset_noedge", out, 16'h0000);
        #1;
        rst_n = 1'b1;
        load  = 1'b0;
        #1;
        check("areset_release", out, 16'h0000);
        sweep("areset_sweep");

        // Reset held across an edge with a pending write: nothing is stored
        tick();
        addr  = 3'd2;
        in    = 16'hBEEF;
        load  = 1'b1;
        rst_n = 1'b0;
        tick();
        check("reset_edge_nowrite", out, 16'h0000);
        load  = 1'b0;
        #2;
        rst_n = 1'b1;
        #1;
        sweep("reset_edge_sweep");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
